// File: rtl/i2c_slv_reg_bank.sv
// Register bank behind the I2C slave: stores master writes, supplies read bytes and per-byte
// ACK, and exposes the same registers to on-chip logic through a local port.
module i2c_slv_reg_bank #(
  parameter int unsigned        DATA_SZ  = 8,
  parameter int unsigned        REG_NUM  = 16,
  parameter logic [DATA_SZ-2:0] SLV_ADDR = 7'h3C,
  parameter logic [REG_NUM-1:0] RO_MASK  = '0
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [DATA_SZ-2:0] I_ADDR_SLV,
  input  logic               I_RW,
  input  logic [DATA_SZ-1:0] I_ADDR_REG,
  input  logic [DATA_SZ-1:0] I_DATA_RD,
  input  logic               I_DATA_VL,
  input  logic               I_BUSY,
  output logic               O_ACK,
  output logic [DATA_SZ-1:0] O_DATA_WR,
  input  logic               I_LCL_WE,
  input  logic [DATA_SZ-1:0] I_LCL_ADDR,
  input  logic [DATA_SZ-1:0] I_LCL_WDATA,
  output logic [DATA_SZ-1:0] O_LCL_RDATA,
  output logic               O_WR_STB,
  output logic [DATA_SZ-1:0] O_WR_IDX
);

  localparam int unsigned        IdxW    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam logic [DATA_SZ:0]   RegNumW = (DATA_SZ + 1)'(REG_NUM);
  localparam logic [DATA_SZ-1:0] LastPtr = DATA_SZ'(REG_NUM - 1);
  localparam logic [DATA_SZ-1:0] PtrOne  = DATA_SZ'(1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StArmed  = 2'd1;
  localparam logic [1:0] StXfer   = 2'd2;
  localparam logic [1:0] StIgnore = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               busy_q;
  logic [DATA_SZ-1:0] ptr_q, ptr_d;
  logic [DATA_SZ-1:0] regs_q [REG_NUM];
  logic [DATA_SZ-1:0] regs_d [REG_NUM];
  logic               ack_q, ack_d;
  logic [DATA_SZ-1:0] data_wr_q, data_wr_d;
  logic [DATA_SZ-1:0] lcl_rdata_q, lcl_rdata_d;
  logic               wr_stb_q, wr_stb_d;
  logic [DATA_SZ-1:0] wr_idx_q, wr_idx_d;

  logic            addr_match;
  logic            ptr_in_range;
  logic [IdxW-1:0] ptr_idx;
  logic            ptr_ro;
  logic            lcl_in_range;
  logic [IdxW-1:0] lcl_idx;
  logic            proc_byte;
  logic            i2c_we;
  logic            lcl_we;

  assign addr_match   = (I_ADDR_SLV == SLV_ADDR);
  assign ptr_in_range = ({1'b0, ptr_q} < RegNumW);
  assign ptr_idx      = ptr_q[IdxW-1:0];
  assign ptr_ro       = RO_MASK[ptr_idx];
  assign lcl_in_range = ({1'b0, I_LCL_ADDR} < RegNumW);
  assign lcl_idx      = I_LCL_ADDR[IdxW-1:0];

  // Dropping I_BUSY aborts from any state; the pointer is held until the next ARMED phase.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    proc_byte = 1'b0;
    if (!I_BUSY) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!busy_q) state_d = StArmed;
        end
        StArmed: begin
          if (!addr_match) begin
            state_d = StIgnore;
            ptr_d   = I_ADDR_REG;
          end else if (I_DATA_VL) begin
            state_d   = StXfer;
            proc_byte = 1'b1;
          end else begin
            ptr_d = I_ADDR_REG;
          end
        end
        StXfer: begin
          if (I_DATA_VL) proc_byte = 1'b1;
        end
        StIgnore: begin
          state_d = StIgnore;
        end
        default: state_d = StIdle;
      endcase
    end
    if (proc_byte) ptr_d = (ptr_q == LastPtr) ? '0 : ptr_q + PtrOne;
  end

  assign i2c_we = proc_byte && !I_RW && ptr_in_range && !ptr_ro;
  assign lcl_we = I_LCL_WE && lcl_in_range;

  // The I2C write is applied last so it wins a same-index collision with the local port.
  always_comb begin
    regs_d = regs_q;
    if (lcl_we) regs_d[lcl_idx] = I_LCL_WDATA;
    if (i2c_we) regs_d[ptr_idx] = I_DATA_RD;
  end

  always_comb begin
    data_wr_d   = ptr_in_range ? regs_q[ptr_idx] : '0;
    lcl_rdata_d = lcl_in_range ? regs_q[lcl_idx] : '0;
    ack_d       = ((state_q == StArmed) || (state_q == StXfer)) && addr_match &&
                  ptr_in_range && (I_RW || !ptr_ro);
    wr_stb_d    = i2c_we;
    wr_idx_d    = i2c_we ? ptr_q : wr_idx_q;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      regs_q      <= '{default: '0};
      ack_q       <= 1'b0;
      data_wr_q   <= '0;
      lcl_rdata_q <= '0;
      wr_stb_q    <= 1'b0;
      wr_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= I_BUSY;
      ptr_q       <= ptr_d;
      regs_q      <= regs_d;
      ack_q       <= ack_d;
      data_wr_q   <= data_wr_d;
      lcl_rdata_q <= lcl_rdata_d;
      wr_stb_q    <= wr_stb_d;
      wr_idx_q    <= wr_idx_d;
    end
  end

  assign O_ACK       = ack_q;
  assign O_DATA_WR   = data_wr_q;
  assign O_LCL_RDATA = lcl_rdata_q;
  assign O_WR_STB    = wr_stb_q;
  assign O_WR_IDX    = wr_idx_q;

endmodule

// File: tb/tb_i2c_slv_reg_bank.sv
// Directed bench for i2c_slv_reg_bank; register 1 is configured read-only from I2C.
module tb_i2c_slv_reg_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] addr_slv;
  logic       rw;
  logic [7:0] addr_reg;
  logic [7:0] data_rd;
  logic       data_vl;
  logic       busy;
  logic       ack;
  logic [7:0] data_wr;
  logic       lcl_we;
  logic [7:0] lcl_addr;
  logic [7:0] lcl_wdata;
  logic [7:0] lcl_rdata;
  logic       wr_stb;
  logic [7:0] wr_idx;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  i2c_slv_reg_bank #(
    .DATA_SZ (8),
    .REG_NUM (16),
    .SLV_ADDR(7'h3C),
    .RO_MASK (16'h0002)
  ) dut (
    .CLK        (clk),
    .RST_n      (rst_n),
    .I_ADDR_SLV (addr_slv),
    .I_RW       (rw),
    .I_ADDR_REG (addr_reg),
    .I_DATA_RD  (data_rd),
    .I_DATA_VL  (data_vl),
    .I_BUSY     (busy),
    .O_ACK      (ack),
    .O_DATA_WR  (data_wr),
    .I_LCL_WE   (lcl_we),
    .I_LCL_ADDR (lcl_addr),
    .I_LCL_WDATA(lcl_wdata),
    .O_LCL_RDATA(lcl_rdata),
    .O_WR_STB   (wr_stb),
    .O_WR_IDX   (wr_idx)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Busy rise is seen on the first edge, the register address is loaded on the second.
  task automatic i2c_start(input logic [6:0] slv, input logic r, input logic [7:0] ra);
    addr_slv = slv;
    rw       = r;
    addr_reg = ra;
    busy     = 1'b1;
    step(2);
  endtask

  task automatic i2c_byte(input logic [7:0] d);
    data_rd = d;
    data_vl = 1'b1;
    step(1);
    data_vl = 1'b0;
  endtask

  task automatic i2c_stop();
    busy = 1'b0;
    step(1);
  endtask

  task automatic lcl_write(input logic [7:0] a, input logic [7:0] d);
    lcl_we    = 1'b1;
    lcl_addr  = a;
    lcl_wdata = d;
    step(1);
    lcl_we    = 1'b0;
  endtask

  task automatic lcl_read(input string tag, input logic [7:0] a, input logic [7:0] exp);
    lcl_addr = a;
    step(1);
    chk(tag, lcl_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    addr_slv  = 7'h00;
    rw        = 1'b0;
    addr_reg  = 8'h00;
    data_rd   = 8'h00;
    data_vl   = 1'b0;
    busy      = 1'b0;
    lcl_we    = 1'b0;
    lcl_addr  = 8'h00;
    lcl_wdata = 8'h00;
    step(2);
    chk("rst_ack", {7'd0, ack}, 8'h00);
    chk("rst_data_wr", data_wr, 8'h00);
    chk("rst_lcl_rdata", lcl_rdata, 8'h00);
    chk("rst_wr_stb", {7'd0, wr_stb}, 8'h00);
    chk("rst_wr_idx", wr_idx, 8'h00);
    rst_n = 1'b1;
    step(1);

    // 1: master write A5,5A starting at reg 2
    i2c_start(7'h3C, 1'b0, 8'h02);
    i2c_byte(8'hA5);
    chk("t1_stb0", {7'd0, wr_stb}, 8'h01);
    chk("t1_idx0", wr_idx, 8'h02);
    chk("t1_ack", {7'd0, ack}, 8'h01);
    i2c_byte(8'h5A);
    chk("t1_stb1", {7'd0, wr_stb}, 8'h01);
    chk("t1_idx1", wr_idx, 8'h03);
    step(1);
    chk("t1_stb_end", {7'd0, wr_stb}, 8'h00);
    i2c_stop();
    lcl_read("t1_reg2", 8'h02, 8'hA5);
    lcl_read("t1_reg3", 8'h03, 8'h5A);

    // 2: master read from reg 15 wrapping to reg 0
    lcl_write(8'h0F, 8'h11);
    lcl_write(8'h00, 8'h22);
    i2c_start(7'h3C, 1'b1, 8'h0F);
    step(1);
    chk("t2_rd15", data_wr, 8'h11);
    chk("t2_ack15", {7'd0, ack}, 8'h01);
    i2c_byte(8'h00);
    step(1);
    chk("t2_rd0", data_wr, 8'h22);
    chk("t2_ack0", {7'd0, ack}, 8'h01);
    i2c_stop();

    // 3: foreign slave address
    i2c_start(7'h3D, 1'b0, 8'h05);
    chk("t3_ack_armed", {7'd0, ack}, 8'h00);
    i2c_byte(8'hFF);
    chk("t3_stb", {7'd0, wr_stb}, 8'h00);
    chk("t3_ack", {7'd0, ack}, 8'h00);
    step(2);
    chk("t3_ack_hold", {7'd0, ack}, 8'h00);
    i2c_stop();
    lcl_read("t3_reg5", 8'h05, 8'h00);

    // 4: read-only reg 1 rejects I2C but accepts local writes
    i2c_start(7'h3C, 1'b0, 8'h01);
    i2c_byte(8'h77);
    chk("t4_ack", {7'd0, ack}, 8'h00);
    chk("t4_stb", {7'd0, wr_stb}, 8'h00);
    i2c_stop();
    lcl_read("t4_reg1_i2c", 8'h01, 8'h00);
    lcl_write(8'h01, 8'h77);
    step(1);
    chk("t4_reg1_lcl", lcl_rdata, 8'h77);

    // 5: collisions, then out-of-range pointer
    i2c_start(7'h3C, 1'b0, 8'h04);
    data_rd   = 8'h33;
    data_vl   = 1'b1;
    lcl_we    = 1'b1;
    lcl_addr  = 8'h04;
    lcl_wdata = 8'h44;
    step(1);
    chk("t5_stb", {7'd0, wr_stb}, 8'h01);
    chk("t5_idx", wr_idx, 8'h04);
    data_rd   = 8'h66;
    lcl_addr  = 8'h06;
    lcl_wdata = 8'h99;
    step(1);
    data_vl = 1'b0;
    lcl_we  = 1'b0;
    chk("t5_idx5", wr_idx, 8'h05);
    i2c_stop();
    lcl_read("t5_reg4", 8'h04, 8'h33);
    lcl_read("t5_reg5", 8'h05, 8'h66);
    lcl_read("t5_reg6", 8'h06, 8'h99);
    lcl_read("t5_lcl_oor", 8'h40, 8'h00);
    i2c_start(7'h3C, 1'b1, 8'h20);
    step(1);
    chk("t5_oor_data", data_wr, 8'h00);
    chk("t5_oor_ack", {7'd0, ack}, 8'h00);
    i2c_stop();

    // 6: reset after the first byte of a three-byte write
    i2c_start(7'h3C, 1'b0, 8'h08);
    i2c_byte(8'h12);
    chk("t6_stb_pre", {7'd0, wr_stb}, 8'h01);
    chk("t6_idx_pre", wr_idx, 8'h08);
    rst_n = 1'b0;
    #2;
    chk("t6_ack", {7'd0, ack}, 8'h00);
    chk("t6_data_wr", data_wr, 8'h00);
    chk("t6_lcl_rdata", lcl_rdata, 8'h00);
    chk("t6_wr_stb", {7'd0, wr_stb}, 8'h00);
    chk("t6_wr_idx", wr_idx, 8'h00);
    busy = 1'b0;
    step(1);
    rst_n = 1'b1;
    lcl_read("t6_reg8", 8'h08, 8'h00);
    lcl_read("t6_reg2", 8'h02, 8'h00);
    lcl_read("t6_reg4", 8'h04, 8'h00);
    lcl_read("t6_reg1", 8'h01, 8'h00);
    lcl_read("t6_reg15", 8'h0F, 8'h00);
    step(2);
    chk("t6_ack_idle", {7'd0, ack}, 8'h00);
    chk("t6_data_idle", data_wr, 8'h00);
    chk("t6_stb_idle", {7'd0, wr_stb}, 8'h00);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
